asic_function_axi_regs: RTL and testbench
=========================================

# asic_function_axi_regs

AXI4-Lite responder and register file for the ASIC function interface: it accepts register writes and reads from the PS/AXI interconnect and starts DAC-drive / XADC-capture conversions. It sits between the AXI slave port of the ASIC function interface top and its DAC SPI controller and XADC capture logic. It also owns the CTRL / DATA_OUT / DATA_IN register map and the conversion busy/done bookkeeping.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width.
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR / S_AXI_AWVALID / S_AXI_AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID / S_AXI_WREADY  in/in/in/out  32/4/1/1  write data channel; WSTRB is ignored.
- S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / S_AXI_ARVALID / S_AXI_ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY  out/out/out/in  32/2/1/1  read data channel.
- dac_start  out  1  one-cycle pulse that starts a conversion.
- dac_data  out  16  DATA_OUT[15:0], driven continuously.
- adc_data_valid  in  1  one-cycle strobe: XADC result ready.
- adc_data  in  16  XADC result; qualified by adc_data_valid.

## Operation
- Register map, decoded on addr[3:2] with addr[15:4]==0:
  - 0x0000 CTRL: bit0 START is write-1 and always reads 0; bit1 BUSY is read-only; bit2 DONE is read-only and sticky.
  - 0x0004 DATA_OUT: read/write; bits [15:0] stored, bits [31:16] read 0.
  - 0x0008 DATA_IN: read-only; bits [15:0] hold the last captured adc_data, upper bits read 0.
  - Unmapped addresses: reads return 0, writes are dropped. BRESP and RRESP are always OKAY (2'b00).
- START=1 write while BUSY=0:
  - dac_start pulses.
  - BUSY is set.
  - DONE is cleared.
- START=1 write while BUSY=1: ignored; no pulse, no state change.
- adc_data_valid while BUSY=1: DATA_IN captures adc_data, BUSY clears, DONE sets.
- adc_data_valid while BUSY=0: ignored.
- Reset values: all READY and VALID outputs 0, RDATA 0, BRESP and RRESP 0, dac_start 0, dac_data 0, BUSY 0, DONE 0, DATA_IN 0.
- Reset mid-conversion returns every output to its reset value. A late adc_data_valid after reset is ignored because BUSY is 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Write FSM, states W_IDLE → W_ACC → W_RESP → W_IDLE:
  - In W_IDLE, the edge that samples AWVALID&WVALID high moves to W_ACC. AWREADY and WREADY are 1 only in W_ACC, so exactly one cycle.
  - In W_ACC, the register is written on the handshake edge. The FSM moves to W_RESP with BVALID=1.
  - BVALID is held until the edge that samples BREADY=1, then the FSM returns to W_IDLE.
  - AW-before-W and W-before-AW are legal: the FSM waits in W_IDLE until both are valid.
- dac_start is high the cycle after the CTRL write handshake edge; BUSY reads 1 from that same cycle.
- Read FSM, states R_IDLE → R_ACC → R_DATA → R_IDLE:
  - ARREADY is 1 for one cycle in R_ACC, and ARADDR is latched.
  - RDATA is sampled from the registers on the R_ACC edge. RVALID=1 is held until RREADY=1, with RDATA stable throughout.
- Read and write FSMs are independent and may overlap.
- DATA_IN read whose R_ACC edge coincides with adc_data_valid: returns the old value.
- CTRL write START coinciding with adc_data_valid while BUSY=1:
  - The capture completes first and BUSY drops.
  - The START is then evaluated against BUSY as seen at the write edge, which is 1, so it is ignored.
- Nominal latency: write BVALID is 2 cycles after both valids are high; read RVALID is 2 cycles after ARVALID.

## Structure
- Package asic_function_pkg holds:
  - CTRL_REG_ADDR=16'h0000, ASIC_DATA_OUT_REG_ADDR=16'h0004, ASIC_DATA_IN_REG_ADDR=16'h0008.
  - CTRL bit indices (START=0, BUSY=1, DONE=2).
  - The write and read FSM state enums.
  - RESP_OKAY=2'b00.
- One sub-module, axi_lite_slave_hs, contains both handshake FSMs. It exports wr_en/wr_addr/wr_data and rd_en/rd_addr/rd_data. The register file and conversion logic stay in the top of this block.

## Test plan
- Reset, then idle 2 cycles -> all READY/VALID outputs 0, dac_data=0; reading CTRL returns 0x0, reading DATA_IN returns 0x0.
- Write 0x00003000 to 0x0004, then read 0x0004 -> RDATA=0x00003000, dac_data=16'h3000; BVALID and RVALID each pulse exactly once.
- Write 0x1 to 0x0000 -> dac_start high for 1 cycle, CTRL reads 0x2. Drive adc_data_valid with adc_data=16'hA5C3 -> CTRL reads 0x4, DATA_IN reads 0x0000A5C3.
- Second START while BUSY -> no dac_start pulse, CTRL stays 0x2. Write 0xFFFFFFFF to 0x0010 -> BRESP=OKAY, no register changes.
- AWVALID asserted 3 cycles before WVALID, with BREADY held low 4 cycles -> single handshake, BVALID held until BREADY; data is written once.
- Assert ARESETN low mid-conversion, then pulse adc_data_valid after release -> BUSY=0, DONE=0, DATA_IN=0.

Source files
------------

// File: rtl/asic_function_axi_regs_pkg.sv
// Shared register map, CTRL bit positions and handshake FSM encodings.
// Combinational constants only; no latency or backpressure of its own.
package asic_function_pkg;
   localparam logic [15:0] CTRL_REG_ADDR          = 16'h0000;
   localparam logic [15:0] ASIC_DATA_OUT_REG_ADDR = 16'h0004;
   localparam logic [15:0] ASIC_DATA_IN_REG_ADDR  = 16'h0008;

   localparam int CTRL_START = 0;
   localparam int CTRL_BUSY  = 1;
   localparam int CTRL_DONE  = 2;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACC, R_DATA} rd_state_t;
endpackage

// File: rtl/asic_function_axi_regs_if.sv
// AXI4-Lite bundle between the interconnect and the register block.
// Pure wiring; flow control is valid/ready on every channel.
interface asic_function_axi_regs_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/asic_function_axi_regs_hs.sv
// Independent AXI4-Lite write/read handshake FSMs; BVALID/RVALID 2 cycles after valid.
// B and R responses are held until BREADY/RREADY; one transaction per channel in flight.
module axi_lite_slave_hs
   import asic_function_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   asic_function_axi_regs_if.slave s_axi,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data
);
   wr_state_t wr_state;
   rd_state_t rd_state;

   logic unused_wstrb;
   assign unused_wstrb = ^s_axi.S_AXI_WSTRB;

   assign s_axi.S_AXI_BRESP = RESP_OKAY;
   assign s_axi.S_AXI_RRESP = RESP_OKAY;
   assign wr_en = (wr_state == W_ACC);
   assign rd_en = (rd_state == R_ACC);

   // Address and data are captured on entry to W_ACC so the commit edge sees stable values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state            <= W_IDLE;
         wr_addr             <= '0;
         wr_data             <= '0;
         s_axi.S_AXI_AWREADY <= 1'b0;
         s_axi.S_AXI_WREADY  <= 1'b0;
         s_axi.S_AXI_BVALID  <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
               wr_addr             <= s_axi.S_AXI_AWADDR;
               wr_data             <= s_axi.S_AXI_WDATA;
               s_axi.S_AXI_AWREADY <= 1'b1;
               s_axi.S_AXI_WREADY  <= 1'b1;
               wr_state            <= W_ACC;
            end
            W_ACC: begin
               s_axi.S_AXI_AWREADY <= 1'b0;
               s_axi.S_AXI_WREADY  <= 1'b0;
               s_axi.S_AXI_BVALID  <= 1'b1;
               wr_state            <= W_RESP;
            end
            W_RESP: if (s_axi.S_AXI_BREADY) begin
               s_axi.S_AXI_BVALID <= 1'b0;
               wr_state           <= W_IDLE;
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state            <= R_IDLE;
         rd_addr             <= '0;
         s_axi.S_AXI_ARREADY <= 1'b0;
         s_axi.S_AXI_RVALID  <= 1'b0;
         s_axi.S_AXI_RDATA   <= '0;
      end else begin
         case (rd_state)
            R_IDLE: if (s_axi.S_AXI_ARVALID) begin
               rd_addr             <= s_axi.S_AXI_ARADDR;
               s_axi.S_AXI_ARREADY <= 1'b1;
               rd_state            <= R_ACC;
            end
            R_ACC: begin
               s_axi.S_AXI_ARREADY <= 1'b0;
               s_axi.S_AXI_RDATA   <= rd_data;
               s_axi.S_AXI_RVALID  <= 1'b1;
               rd_state            <= R_DATA;
            end
            R_DATA: if (s_axi.S_AXI_RREADY) begin
               s_axi.S_AXI_RVALID <= 1'b0;
               rd_state           <= R_IDLE;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/asic_function_axi_regs.sv
// CTRL/DATA_OUT/DATA_IN register file with DAC start and XADC capture bookkeeping.
// Write response 2 cycles after AW+W valid, read data 2 cycles after ARVALID; held until ready.
module asic_function_axi_regs
   import asic_function_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 16
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESETN,
   asic_function_axi_regs_if.slave s_axi,
   output logic        dac_start,
   output logic [15:0] dac_data,
   input  logic        adc_data_valid,
   input  logic [15:0] adc_data
);
   logic                          wr_en;
   logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
   logic                          rd_en;
   logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
   logic                          busy;
   logic                          done;
   logic [15:0]                   data_in;
   logic                          unused_bits;

   axi_lite_slave_hs #(
      .ADDR_W (C_S_AXI_ADDR_WIDTH),
      .DATA_W (C_S_AXI_DATA_WIDTH)
   ) u_hs (
      .clk     (S_AXI_ACLK),
      .rst_n   (S_AXI_ARESETN),
      .s_axi   (s_axi),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign unused_bits = ^{wr_data[31:16], wr_addr[1:0], rd_addr[1:0], rd_en};

   always_comb begin
      rd_data = '0;
      if (rd_addr[15:2] == CTRL_REG_ADDR[15:2]) begin
         rd_data[CTRL_BUSY] = busy;
         rd_data[CTRL_DONE] = done;
      end else if (rd_addr[15:2] == ASIC_DATA_OUT_REG_ADDR[15:2]) begin
         rd_data[15:0] = dac_data;
      end else if (rd_addr[15:2] == ASIC_DATA_IN_REG_ADDR[15:2]) begin
         rd_data[15:0] = data_in;
      end
   end

   // START is judged against the pre-edge BUSY, so a capture on the same edge wins.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         dac_start <= 1'b0;
         dac_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         data_in   <= '0;
      end else begin
         dac_start <= 1'b0;
         if (adc_data_valid && busy) begin
            data_in <= adc_data;
            busy    <= 1'b0;
            done    <= 1'b1;
         end
         if (wr_en) begin
            if (wr_addr[15:2] == CTRL_REG_ADDR[15:2]) begin
               if (wr_data[CTRL_START] && !busy) begin
                  dac_start <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end else if (wr_addr[15:2] == ASIC_DATA_OUT_REG_ADDR[15:2]) begin
               dac_data <= wr_data[15:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_asic_function_axi_regs.sv
// Directed bench for the ASIC function AXI register block.
module tb_asic_function_axi_regs;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dac_start;
   logic [15:0] dac_data;
   logic        adc_data_valid;
   logic [15:0] adc_data;

   int n_checks = 0;
   int n_fails  = 0;
   int start_cnt = 0;
   int b_cnt = 0;
   int r_cnt = 0;

   always #5 clk = ~clk;

   asic_function_axi_regs_if #(.ADDR_W(16), .DATA_W(32)) axi ();

   asic_function_axi_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (16)
   ) dut (
      .S_AXI_ACLK     (clk),
      .S_AXI_ARESETN  (rst_n),
      .s_axi          (axi.slave),
      .dac_start      (dac_start),
      .dac_data       (dac_data),
      .adc_data_valid (adc_data_valid),
      .adc_data       (adc_data)
   );

   always @(posedge clk) begin
      if (dac_start) start_cnt <= start_cnt + 1;
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) b_cnt <= b_cnt + 1;
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) r_cnt <= r_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [15:0] addr, input logic [31:0] data);
      int k;
      axi.S_AXI_AWADDR  = addr;
      axi.S_AXI_WDATA   = data;
      axi.S_AXI_WSTRB   = 4'hF;
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WVALID  = 1'b1;
      k = 0;
      while (!axi.S_AXI_AWREADY && k < 20) begin tick(); k++; end
      chk("wr_awready_seen", {31'b0, axi.S_AXI_AWREADY && axi.S_AXI_WREADY}, 32'd1);
      tick();
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      k = 0;
      while (!axi.S_AXI_BVALID && k < 20) begin tick(); k++; end
      chk("wr_bvalid_seen", {31'b0, axi.S_AXI_BVALID}, 32'd1);
      chk("wr_bresp", {30'b0, axi.S_AXI_BRESP}, 32'd0);
      axi.S_AXI_BREADY = 1'b1;
      tick();
      axi.S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] addr, output logic [31:0] data);
      int k;
      axi.S_AXI_ARADDR  = addr;
      axi.S_AXI_ARVALID = 1'b1;
      k = 0;
      while (!axi.S_AXI_ARREADY && k < 20) begin tick(); k++; end
      chk("rd_arready_seen", {31'b0, axi.S_AXI_ARREADY}, 32'd1);
      tick();
      axi.S_AXI_ARVALID = 1'b0;
      k = 0;
      while (!axi.S_AXI_RVALID && k < 20) begin tick(); k++; end
      chk("rd_rvalid_seen", {31'b0, axi.S_AXI_RVALID}, 32'd1);
      chk("rd_rresp", {30'b0, axi.S_AXI_RRESP}, 32'd0);
      data = axi.S_AXI_RDATA;
      axi.S_AXI_RREADY = 1'b1;
      tick();
      axi.S_AXI_RREADY = 1'b0;
   endtask

   task automatic adc_pulse(input logic [15:0] val);
      adc_data       = val;
      adc_data_valid = 1'b1;
      tick();
      adc_data_valid = 1'b0;
   endtask

   function automatic logic [31:0] hs_outs();
      return {27'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
              axi.S_AXI_ARREADY, axi.S_AXI_RVALID};
   endfunction

   initial begin
      logic [31:0] rd;
      int s0, b0, r0;
      axi.S_AXI_AWADDR  = '0;
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WDATA   = '0;
      axi.S_AXI_WSTRB   = '0;
      axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY  = 1'b0;
      axi.S_AXI_ARADDR  = '0;
      axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY  = 1'b0;
      adc_data_valid    = 1'b0;
      adc_data          = '0;

      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("reset_hs_outputs", hs_outs(), 32'd0);
      chk("reset_dac_data", {16'b0, dac_data}, 32'd0);
      chk("reset_dac_start", {31'b0, dac_start}, 32'd0);
      chk("reset_rdata", axi.S_AXI_RDATA, 32'd0);
      axi_read(16'h0000, rd); chk("reset_ctrl", rd, 32'h0);
      axi_read(16'h0008, rd); chk("reset_data_in", rd, 32'h0);

      b0 = b_cnt; r0 = r_cnt;
      axi_write(16'h0004, 32'h0000_3000);
      axi_read(16'h0004, rd);
      chk("data_out_read", rd, 32'h0000_3000);
      chk("dac_data_3000", {16'b0, dac_data}, 32'h3000);
      chk("b_handshakes_1", b_cnt - b0, 32'd1);
      chk("r_handshakes_1", r_cnt - r0, 32'd1);

      s0 = start_cnt;
      axi_write(16'h0000, 32'h1);
      chk("start_pulse_cycles", start_cnt - s0, 32'd1);
      chk("start_pulse_low", {31'b0, dac_start}, 32'd0);
      axi_read(16'h0000, rd); chk("ctrl_busy", rd, 32'h2);
      adc_pulse(16'hA5C3);
      axi_read(16'h0000, rd); chk("ctrl_done", rd, 32'h4);
      axi_read(16'h0008, rd); chk("data_in_a5c3", rd, 32'h0000_A5C3);

      s0 = start_cnt;
      axi_write(16'h0000, 32'h1);
      chk("restart_pulse", start_cnt - s0, 32'd1);
      axi_read(16'h0000, rd); chk("restart_ctrl", rd, 32'h2);
      s0 = start_cnt;
      axi_write(16'h0000, 32'h1);
      chk("busy_start_no_pulse", start_cnt - s0, 32'd0);
      axi_read(16'h0000, rd); chk("busy_start_ctrl", rd, 32'h2);
      axi_write(16'h0010, 32'hFFFF_FFFF);
      axi_read(16'h0004, rd); chk("unmapped_wr_data_out", rd, 32'h0000_3000);
      axi_read(16'h0000, rd); chk("unmapped_wr_ctrl", rd, 32'h2);
      axi_read(16'h0008, rd); chk("unmapped_wr_data_in", rd, 32'h0000_A5C3);
      axi_read(16'h0010, rd); chk("unmapped_read", rd, 32'h0);

      b0 = b_cnt;
      axi.S_AXI_AWADDR  = 16'h0004;
      axi.S_AXI_WDATA   = 32'h0000_1234;
      axi.S_AXI_AWVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("aw_only_no_ready", {31'b0, axi.S_AXI_AWREADY}, 32'd0);
      end
      axi.S_AXI_WVALID = 1'b1;
      tick();
      chk("aw_w_ready", {30'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'd3);
      tick();
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      chk("aw_w_bvalid", {31'b0, axi.S_AXI_BVALID}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bvalid_held", {29'b0, axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'd4);
      end
      axi.S_AXI_BREADY = 1'b1;
      tick();
      axi.S_AXI_BREADY = 1'b0;
      chk("bvalid_dropped", {31'b0, axi.S_AXI_BVALID}, 32'd0);
      chk("aw_w_single_b", b_cnt - b0, 32'd1);
      axi_read(16'h0004, rd); chk("aw_w_data_out", rd, 32'h0000_1234);
      chk("dac_data_1234", {16'b0, dac_data}, 32'h1234);

      rst_n = 1'b0;
      tick();
      chk("midreset_hs_outputs", hs_outs(), 32'd0);
      chk("midreset_dac", {15'b0, dac_start, dac_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      adc_pulse(16'hBEEF);
      axi_read(16'h0000, rd); chk("post_reset_ctrl", rd, 32'h0);
      axi_read(16'h0008, rd); chk("post_reset_data_in", rd, 32'h0);
      chk("post_reset_dac_data", {16'b0, dac_data}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
